omp_ram_dp: RTL and testbench

- Parametrised true dual-port block RAM for the OMP datapath, successor to the single-port Q store.
- Two independent read/write ports with per-byte write enables and a selectable read-during-write mode.
- A post-reset clear sequencer zeroes every word before the ports are released.
- A collision flag reports same-address conflicts between the two ports.

---
 rtl/omp_ram_pkg.sv | 21 ++
 rtl/omp_ram_clr_seq.sv | 59 +++++
 rtl/omp_ram_dp.sv | 175 +++++++++++++++++
 tb/tb_omp_ram_dp.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/omp_ram_pkg.sv
// ============================================================================
// Module      : omp_ram_pkg
// Description : Shared constants and FSM encoding for the omp_ram_dp RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package omp_ram_pkg;

    localparam int RDW_WRITE_FIRST = 0;
    localparam int RDW_READ_FIRST  = 1;
    localparam int RDW_NO_CHANGE   = 2;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

endpackage

`default_nettype wire

// File: rtl/omp_ram_clr_seq.sv
// ============================================================================
// Module      : omp_ram_clr_seq
// Description : Post-reset clear sequencer; walks every word once, then READY.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module omp_ram_clr_seq
    import omp_ram_pkg::*;
#(
    parameter int AWIDTH   = 11,
    parameter int MEM_SIZE = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr,
    output logic              init_done
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

    clr_state_e        state_q, state_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_addr  = cnt_q;
    assign init_done = (state_q == READY);

endmodule

`default_nettype wire

// File: rtl/omp_ram_dp.sv
// ============================================================================
// Module      : omp_ram_dp
// Description : True dual-port byte-enabled RAM with clear-on-reset and
//               same-address collision flag. OMP_RAM_OUTREG_EN adds an
//               output register stage (2-cycle read latency).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module omp_ram_dp
    import omp_ram_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 11,
    parameter int MEM_SIZE = 2048,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AWIDTH-1:0]   addr0,
    input  logic                ce0,
    input  logic [DWIDTH/8-1:0] we0,
    input  logic [DWIDTH-1:0]   d0,
    output logic [DWIDTH-1:0]   q0,
    input  logic [AWIDTH-1:0]   addr1,
    input  logic                ce1,
    input  logic [DWIDTH/8-1:0] we1,
    input  logic [DWIDTH-1:0]   d1,
    output logic [DWIDTH-1:0]   q1,
    output logic                init_done,
    output logic                coll
);

    localparam int                NB       = DWIDTH / 8;
    localparam logic [AWIDTH:0]   MEM_SZ_W = (AWIDTH + 1)'(MEM_SIZE);

    logic [DWIDTH-1:0] mem [MEM_SIZE];

    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    omp_ram_clr_seq #(
        .AWIDTH   (AWIDTH),
        .MEM_SIZE (MEM_SIZE)
    ) u_clr_seq (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr),
        .init_done (init_done)
    );

    function automatic logic [DWIDTH-1:0] merge_bytes(
        input logic [DWIDTH-1:0] old_w,
        input logic [DWIDTH-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DWIDTH-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [DWIDTH-1:0] rd_next(
        input logic [DWIDTH-1:0] q_cur,
        input logic [DWIDTH-1:0] old_w,
        input logic [DWIDTH-1:0] wdata,
        input logic [NB-1:0]     be,
        input logic              ce,
        input logic              in_range
    );
        logic [DWIDTH-1:0] r;
        r = q_cur;
        if (ce) begin
            if (!in_range) begin
                r = '0;
            end else if (be == '0) begin
                r = old_w;
            end else begin
                case (RDW_MODE)
                    RDW_WRITE_FIRST: r = merge_bytes(old_w, wdata, be);
                    RDW_READ_FIRST:  r = old_w;
                    default:         r = q_cur;
                endcase
            end
        end
        return r;
    endfunction

    logic in0, in1;
    assign in0 = ({1'b0, addr0} < MEM_SZ_W);
    assign in1 = ({1'b0, addr1} < MEM_SZ_W);

    // Clear sequencer borrows the port-A write path until init_done.
    logic              wa_en, wb_en;
    logic [AWIDTH-1:0] wa_addr;
    logic [NB-1:0]     wa_be;
    logic [DWIDTH-1:0] wa_data;

    assign wa_en   = clr_we | (init_done & ce0 & in0);
    assign wa_addr = clr_we ? clr_addr : addr0;
    assign wa_be   = clr_we ? {NB{1'b1}} : we0;
    assign wa_data = clr_we ? '0 : d0;
    assign wb_en   = init_done & ce1 & in1;

    // Port A is written last so it wins overlapping bytes.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (wb_en && we1[k]) mem[addr1][8*k +: 8] <= d1[8*k +: 8];
            if (wa_en && wa_be[k]) mem[wa_addr][8*k +: 8] <= wa_data[8*k +: 8];
        end
    end

    logic [DWIDTH-1:0] q0_q, q0_d, q1_q, q1_d;
    logic              coll_q, coll_d;

    always_comb begin
        q0_d   = '0;
        q1_d   = '0;
        coll_d = 1'b0;
        if (init_done) begin
            q0_d   = rd_next(q0_q, mem[addr0], d0, we0, ce0, in0);
            q1_d   = rd_next(q1_q, mem[addr1], d1, we1, ce1, in1);
            coll_d = ce0 & ce1 & (addr0 == addr1) & ((|we0) | (|we1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0_q   <= '0;
            q1_q   <= '0;
            coll_q <= 1'b0;
        end else begin
            q0_q   <= q0_d;
            q1_q   <= q1_d;
            coll_q <= coll_d;
        end
    end

`ifdef OMP_RAM_OUTREG_EN
    logic [DWIDTH-1:0] q0_o_q, q0_o_d, q1_o_q, q1_o_d;
    logic              coll_o_q, coll_o_d;

    always_comb begin
        q0_o_d   = init_done ? q0_q : '0;
        q1_o_d   = init_done ? q1_q : '0;
        coll_o_d = init_done & coll_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q0_o_q   <= '0;
            q1_o_q   <= '0;
            coll_o_q <= 1'b0;
        end else begin
            q0_o_q   <= q0_o_d;
            q1_o_q   <= q1_o_d;
            coll_o_q <= coll_o_d;
        end
    end

    assign q0   = q0_o_q;
    assign q1   = q1_o_q;
    assign coll = coll_o_q;
`else
    assign q0   = q0_q;
    assign q1   = q1_q;
    assign coll = coll_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_omp_ram_dp.sv
// ============================================================================
// Module      : tb_omp_ram_dp
// Description : Directed self-checking bench for omp_ram_dp (16 x 32 bit),
//               one instance per read-during-write mode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_omp_ram_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  addr0, addr1, we0, we1;
    logic        ce0, ce1;
    logic [31:0] d0, d1;
    logic [31:0] q0_m0, q1_m0, q0_m1, q1_m1, q0_m2, q1_m2;
    logic        init_m0, init_m1, init_m2, coll_m0, coll_m1, coll_m2;

    int vectors = 0;
    int miscompares = 0;
    int n;

    always #5 clk = ~clk;

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(4), .MEM_SIZE(16), .RDW_MODE(0)) u_m0 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_m0),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_m0),
        .init_done(init_m0), .coll(coll_m0));

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(4), .MEM_SIZE(16), .RDW_MODE(1)) u_m1 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_m1),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_m1),
        .init_done(init_m1), .coll(coll_m1));

    omp_ram_dp #(.DWIDTH(32), .AWIDTH(4), .MEM_SIZE(16), .RDW_MODE(2)) u_m2 (
        .clk(clk), .rst_n(rst_n),
        .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0), .q0(q0_m2),
        .addr1(addr1), .ce1(ce1), .we1(we1), .d1(d1), .q1(q1_m2),
        .init_done(init_m2), .coll(coll_m2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One read on each port, waits until the data reaches the outputs.
    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        addr0 = a0; addr1 = a1; ce0 = 1'b1; ce1 = 1'b1; we0 = '0; we1 = '0;
        tick();
        ce0 = 1'b0; ce1 = 1'b0;
`ifdef OMP_RAM_OUTREG_EN
        tick();
`endif
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [3:0] be, input logic [31:0] dat);
        addr0 = a; we0 = be; d0 = dat; ce0 = 1'b1;
        tick();
        ce0 = 1'b0; we0 = '0;
`ifdef OMP_RAM_OUTREG_EN
        tick();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        addr0 = '0; addr1 = '0; ce0 = 1'b0; ce1 = 1'b0;
        we0 = '0; we1 = '0; d0 = '0; d1 = '0;
        repeat (3) tick();
        check("rst_init_done", {31'b0, init_m0}, 32'd0);
        check("rst_q0", q0_m0, 32'h0);
        check("rst_q1", q1_m0, 32'h0);
        check("rst_coll", {31'b0, coll_m0}, 32'd0);

        // Release with writes hammering both ports during CLEAR.
        rst_n = 1'b1;
        ce0 = 1'b1; we0 = 4'hF; d0 = 32'hFFFF_FFFF;
        ce1 = 1'b1; we1 = 4'hF; d1 = 32'hA5A5_A5A5;
        n = 0;
        while (!init_m0 && n < 40) begin
            addr0 = n[3:0]; addr1 = n[3:0];
            tick();
            n++;
        end
        ce0 = 1'b0; ce1 = 1'b0; we0 = '0; we1 = '0;
        check("init_latency", n, 32'd16);
        check("clear_q0", q0_m0, 32'h0);
        check("clear_coll", {31'b0, coll_m0}, 32'd0);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a), 4'(15 - a));
            check("init_rd_q0", q0_m0, 32'h0);
            check("init_rd_q1", q1_m0, 32'h0);
        end

        // Read-during-write per mode.
        wr_a(4'd3, 4'hF, 32'h1122_3344);
        check("rdw_full_m0", q0_m0, 32'h1122_3344);
        check("rdw_full_m1", q0_m1, 32'h0);
        check("rdw_full_m2", q0_m2, 32'h0);
        wr_a(4'd3, 4'h3, 32'hAABB_CCDD);
        check("rdw_part_m0", q0_m0, 32'h1122_CCDD);
        check("rdw_part_m1", q0_m1, 32'h1122_3344);
        check("rdw_part_m2", q0_m2, 32'h0);
        rd(4'd3, 4'd3);
        check("rdw_mem_m2", q0_m2, 32'h1122_CCDD);
        check("rdw_mem_m1", q1_m1, 32'h1122_CCDD);

        // Same-address double write and collision pulse.
        addr0 = 4'd5; we0 = 4'h3; d0 = 32'h0000_FFFF; ce0 = 1'b1;
        addr1 = 4'd5; we1 = 4'hF; d1 = 32'h1234_5678; ce1 = 1'b1;
        tick();
        ce0 = 1'b0; ce1 = 1'b0; we0 = '0; we1 = '0;
`ifdef OMP_RAM_OUTREG_EN
        check("coll_early", {31'b0, coll_m0}, 32'd0);
        tick();
`endif
        check("coll_pulse", {31'b0, coll_m0}, 32'd1);
        tick();
        check("coll_end", {31'b0, coll_m0}, 32'd0);
        rd(4'd0, 4'd5);
        check("dual_wr_merge", q1_m0, 32'h1234_FFFF);

        // Cross-port read of a word being written returns the old word.
        addr0 = 4'd7; we0 = 4'hF; d0 = 32'hDEAD_BEEF; ce0 = 1'b1;
        addr1 = 4'd7; ce1 = 1'b1;
        tick();
        ce0 = 1'b0; we0 = '0;
`ifdef OMP_RAM_OUTREG_EN
        tick();
        ce1 = 1'b0;
        check("xport_old", q1_m0, 32'h0);
        tick();
        check("xport_new", q1_m0, 32'hDEAD_BEEF);
`else
        check("xport_old", q1_m0, 32'h0);
        tick();
        ce1 = 1'b0;
        check("xport_new", q1_m0, 32'hDEAD_BEEF);
`endif

        // Read latency on port A.
        rd(4'd0, 4'd0);
        addr0 = 4'd7; ce0 = 1'b1;
        tick();
        ce0 = 1'b0;
`ifdef OMP_RAM_OUTREG_EN
        check("lat_not_yet", q0_m0, 32'h0);
        tick();
`endif
        check("lat_data", q0_m0, 32'hDEAD_BEEF);

        // Reset mid-traffic wipes the contents.
        wr_a(4'd2, 4'hF, 32'h0000_0055);
        rd(4'd2, 4'd2);
        check("pre_rst_rd", q0_m0, 32'h0000_0055);
        addr1 = 4'd2; ce1 = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_init_done", {31'b0, init_m0}, 32'd0);
        check("rst2_q0", q0_m0, 32'h0);
        n = 0;
        while (!init_m0 && n < 40) begin
            tick();
            n++;
        end
        ce1 = 1'b0;
        check("rst2_latency", n, 32'd16);
        rd(4'd2, 4'd2);
        check("rst2_rd_q0", q0_m0, 32'h0);
        check("rst2_rd_q1", q1_m1, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
